rpl_capture_unit: RTL and testbench

- Downstream companion of the RPL matcher VM core: consumes the VM's capture commands (open, close, rollback on backtrack, finish) and maintains the capture tree (name, start/end position, level, parent).
- At end of match it streams every matched capture record, in creation order, to the result consumer.
- It also returns the current capture index to the VM so backtrack entries can save and restore it.

---
 rtl/rpl_cap_pkg.sv | 33 +++
 rtl/rpl_cap_table.sv | 40 ++++
 rtl/rpl_capture_unit.sv | 180 ++++++++++++++++++
 tb/tb_rpl_capture_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpl_cap_pkg.sv
// Shared types for the RPL capture unit: command opcodes, FSM states and the
// capture record layout held in the capture table.
package rpl_cap_pkg;

  localparam int CAP_POS_W  = 16;
  localparam int CAP_NAME_W = 8;
  localparam int CAP_DEPTH  = 64;
  localparam int CAP_IDX_W  = $clog2(CAP_DEPTH);
  localparam int CAP_LVL_W  = 6;

  typedef enum logic [1:0] {
    OP_OPEN     = 2'd0,
    OP_CLOSE    = 2'd1,
    OP_ROLLBACK = 2'd2,
    OP_FINISH   = 2'd3
  } cap_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic                  matched;
    logic [CAP_NAME_W-1:0] name;
    logic [CAP_POS_W-1:0]  start_pos;
    logic [CAP_POS_W-1:0]  end_pos;
    logic [CAP_LVL_W-1:0]  level;
    logic [CAP_IDX_W-1:0]  parent;
  } cap_rec_t;

endpackage

// File: rtl/rpl_cap_table.sv
// Capture record storage: one full-record write port for OPEN, a field write of
// end/matched for CLOSE, and two asynchronous read ports (current and scan).
module rpl_cap_table
  import rpl_cap_pkg::*;
#(
  parameter int DEPTH = CAP_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  cap_rec_t             wr_data,
  input  logic                 cl_en,
  input  logic [IDX_W-1:0]     cl_addr,
  input  logic [CAP_POS_W-1:0] cl_end,
  input  logic [IDX_W-1:0]     rd_a_addr,
  output logic [CAP_LVL_W-1:0] rd_a_level,
  output logic [IDX_W-1:0]     rd_a_parent,
  input  logic [IDX_W-1:0]     rd_b_addr,
  output cap_rec_t             rd_b_data
);

  cap_rec_t mem [DEPTH];

  // Entries are never cleared; the owner tracks which ones are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (cl_en) begin
      mem[cl_addr].end_pos <= cl_end;
      mem[cl_addr].matched <= 1'b1;
    end
  end

  assign rd_a_level  = mem[rd_a_addr].level;
  assign rd_a_parent = mem[rd_a_addr].parent;
  assign rd_b_data   = mem[rd_b_addr];

endmodule

// File: rtl/rpl_capture_unit.sv
// Capture tree builder for the RPL matcher: applies OPEN/CLOSE/ROLLBACK/FINISH
// commands and streams matched capture records in creation order at finish.
module rpl_capture_unit
  import rpl_cap_pkg::*;
#(
  parameter int POS_W  = CAP_POS_W,
  parameter int NAME_W = CAP_NAME_W,
  parameter int DEPTH  = CAP_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int LVL_W  = CAP_LVL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [NAME_W-1:0] cmd_name,
  input  logic [POS_W-1:0]  cmd_pos,
  input  logic [IDX_W-1:0]  cmd_idx,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NAME_W-1:0] out_name,
  output logic [POS_W-1:0]  out_start,
  output logic [POS_W-1:0]  out_end,
  output logic [LVL_W-1:0]  out_level,
  output logic [IDX_W-1:0]  out_parent,
  output logic              out_last,
  output logic              done,
  output logic              match_ok,
  output logic [POS_W-1:0]  match_end,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EMIT = ST_EMIT;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       state;
  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] scan;
  logic [IDX_W-1:0] last_m;
  logic             has_m;

  logic             is_full;
  logic             is_empty;
  logic             cmd_fire;
  logic             wr_en;
  logic             cl_en;
  cap_rec_t         wr_rec;
  cap_rec_t         rec_scan;
  logic [LVL_W-1:0] cur_level;
  logic [IDX_W-1:0] cur_parent;
  logic [IDX_W-1:0] scan_addr;

  assign is_full   = (count == (IDX_W+1)'(DEPTH));
  assign is_empty  = (count == '0);
  assign cmd_ready = (state == S_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cur_idx   = cur;

  // The scan port doubles as the entry-0 reader while reporting the result.
  assign scan_addr = (state == S_DONE) ? '0 : scan;
  assign done      = (state == S_DONE);
  assign match_ok  = done && !is_empty && rec_scan.matched;
  assign match_end = match_ok ? rec_scan.end_pos : '0;

  always_comb begin
    wr_en            = cmd_fire && (cmd_op == OP_OPEN) && !is_full;
    cl_en            = cmd_fire && (cmd_op == OP_CLOSE) && !is_empty;
    wr_rec           = '0;
    wr_rec.name      = cmd_name;
    wr_rec.start_pos = cmd_pos;
    wr_rec.level     = is_empty ? '0 : cur_level + 1'b1;
    wr_rec.parent    = cur;
  end

  rpl_cap_table #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_table (
    .clk        (clk),
    .wr_en      (wr_en),
    .wr_addr    (count[IDX_W-1:0]),
    .wr_data    (wr_rec),
    .cl_en      (cl_en),
    .cl_addr    (cur),
    .cl_end     (cmd_pos),
    .rd_a_addr  (cur),
    .rd_a_level (cur_level),
    .rd_a_parent(cur_parent),
    .rd_b_addr  (scan_addr),
    .rd_b_data  (rec_scan)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      cur        <= '0;
      scan       <= '0;
      last_m     <= '0;
      has_m      <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      out_valid  <= 1'b0;
      out_name   <= '0;
      out_start  <= '0;
      out_end    <= '0;
      out_level  <= '0;
      out_parent <= '0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_OPEN: begin
                if (is_full) begin
                  overflow <= 1'b1;
                end else begin
                  cur   <= count[IDX_W-1:0];
                  count <= count + 1'b1;
                end
              end
              OP_CLOSE: begin
                if (is_empty) begin
                  underflow <= 1'b1;
                end else begin
                  cur   <= cur_parent;
                  has_m <= 1'b1;
                  if (cur > last_m) last_m <= cur;
                end
              end
              OP_ROLLBACK: begin
                cur <= ({1'b0, cmd_idx} < count) ? cmd_idx : '0;
              end
              default: begin
                scan  <= '0;
                state <= (is_empty || !has_m) ? S_DONE : S_EMIT;
              end
            endcase
          end
        end
        // Unmatched entries cost one idle cycle; the highest matched index ends the stream.
        S_EMIT: begin
          if (!out_valid || out_ready) begin
            if (out_valid && out_last) begin
              out_valid <= 1'b0;
              state     <= S_DONE;
            end else begin
              scan      <= scan + 1'b1;
              out_valid <= rec_scan.matched;
              if (rec_scan.matched) begin
                out_name   <= rec_scan.name;
                out_start  <= rec_scan.start_pos;
                out_end    <= rec_scan.end_pos;
                out_level  <= rec_scan.level;
                out_parent <= rec_scan.parent;
                out_last   <= (scan == last_m);
              end
            end
          end
        end
        S_DONE: begin
          count  <= '0;
          cur    <= '0;
          scan   <= '0;
          last_m <= '0;
          has_m  <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpl_capture_unit.sv
// Scoreboard bench for rpl_capture_unit: a behavioural capture-tree model
// predicts emitted records and match results; a monitor checks the DUT stream.
module tb_rpl_capture_unit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [7:0]  cmd_name = '0;
  logic [15:0] cmd_pos = '0;
  logic [5:0]  cmd_idx = '0;
  logic [5:0]  cur_idx;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_name;
  logic [15:0] out_start;
  logic [15:0] out_end;
  logic [5:0]  out_level;
  logic [5:0]  out_parent;
  logic        out_last;
  logic        done;
  logic        match_ok;
  logic [15:0] match_end;
  logic        overflow;
  logic        underflow;

  rpl_capture_unit dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_name(cmd_name), .cmd_pos(cmd_pos), .cmd_idx(cmd_idx),
    .cur_idx(cur_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_name(out_name),
    .out_start(out_start), .out_end(out_end), .out_level(out_level),
    .out_parent(out_parent), .out_last(out_last),
    .done(done), .match_ok(match_ok), .match_end(match_end),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int name;
    int start;
    int fin;
    int level;
    int parent;
    bit last;
  } exp_rec_t;

  typedef struct {
    bit ok;
    int fin;
  } exp_done_t;

  exp_rec_t  exp_q[$];
  exp_done_t done_q[$];
  exp_rec_t  er;
  exp_done_t ed;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  // Behavioural capture tree
  int m_count, m_cur;
  bit m_ovf, m_unf;
  int m_name[DEPTH], m_start[DEPTH], m_end[DEPTH], m_level[DEPTH], m_parent[DEPTH];
  bit m_matched[DEPTH];

  bit ready_rand = 1'b0;
  bit ready_hold = 1'b1;
  bit ready_pat[$];

  always @(posedge clk) begin
    #2;
    if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
    else if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    else out_ready = ready_hold;
  end

  // Every presented record (stalled or not) must equal the head of the queue.
  always @(negedge clk) begin
    if (out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_record: got name=%0d start=%0d end=%0d, required no record",
                 out_name, out_start, out_end);
      end else begin
        er = exp_q[0];
        if (int'(out_name) != er.name || int'(out_start) != er.start || int'(out_end) != er.fin ||
            int'(out_level) != er.level || int'(out_parent) != er.parent || out_last != er.last) begin
          n_fail++;
          $display("[TB] FAIL record: got {%0d,%0d,%0d,lvl%0d,par%0d,last%0d} required {%0d,%0d,%0d,lvl%0d,par%0d,last%0d}",
                   out_name, out_start, out_end, out_level, out_parent, out_last,
                   er.name, er.start, er.fin, er.level, er.parent, er.last);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
    if (done) begin
      done_cnt++;
      n_cmp++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1, required 0");
      end else begin
        ed = done_q.pop_front();
        if (match_ok != ed.ok || int'(match_end) != ed.fin) begin
          n_fail++;
          $display("[TB] FAIL match_result: got ok=%0d end=%0d required ok=%0d end=%0d",
                   match_ok, match_end, ed.ok, ed.fin);
        end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("[TB] FAIL records_left: got %0d records still pending at done, required 0", exp_q.size());
      end
    end
  end

  task automatic checkOutput(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic modelClear();
    m_count = 0;
    m_cur = 0;
    m_ovf = 0;
    m_unf = 0;
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic modelCommand(input int op, input int nm, input int pos, input int idx);
    int last_i;
    case (op)
      0: begin
        if (m_count == DEPTH) m_ovf = 1;
        else begin
          m_name[m_count]    = nm;
          m_start[m_count]   = pos;
          m_end[m_count]     = 0;
          m_matched[m_count] = 0;
          m_level[m_count]   = (m_count == 0) ? 0 : (m_level[m_cur] + 1) % 64;
          m_parent[m_count]  = m_cur;
          m_cur = m_count;
          m_count++;
        end
      end
      1: begin
        if (m_count == 0) m_unf = 1;
        else begin
          m_end[m_cur]     = pos;
          m_matched[m_cur] = 1;
          m_cur = m_parent[m_cur];
        end
      end
      2: m_cur = (idx < m_count) ? idx : 0;
      default: begin
        last_i = -1;
        for (int i = 0; i < m_count; i++) if (m_matched[i]) last_i = i;
        for (int i = 0; i < m_count; i++)
          if (m_matched[i])
            exp_q.push_back('{m_name[i], m_start[i], m_end[i], m_level[i], m_parent[i], i == last_i});
        if (m_count > 0 && m_matched[0]) done_q.push_back('{1'b1, m_end[0]});
        else done_q.push_back('{1'b0, 0});
        m_count = 0;
        m_cur = 0;
      end
    endcase
  endtask

  task automatic applyStimulus(input int op, input int nm, input int pos, input int idx);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL cmd_ready_timeout: got cmd_ready=0 after %0d cycles, required 1", n);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_name  = nm[7:0];
    cmd_pos   = pos[15:0];
    cmd_idx   = idx[5:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    modelCommand(op, nm, pos, idx);
    if (op != 3) begin
      checkOutput("cur_idx", int'(cur_idx), m_cur);
      checkOutput("overflow", int'(overflow), int'(m_ovf));
      checkOutput("underflow", int'(underflow), int'(m_unf));
    end
  endtask

  task automatic waitIdle(input int done_before);
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle_after_finish", int'(cmd_ready), 1);
    checkOutput("done_pulses", done_cnt - done_before, 1);
    checkOutput("records_drained", exp_q.size(), 0);
  endtask

  task automatic finishMatch();
    int d0 = done_cnt;
    applyStimulus(3, 0, 0, 0);
    waitIdle(d0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelClear();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs0, d0, n, lim;
    modelClear();
    doReset();

    checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("rst_cur_idx", int'(cur_idx), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_name", int'(out_name), 0);
    checkOutput("rst_out_last", int'(out_last), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_match_ok", int'(match_ok), 0);
    checkOutput("rst_match_end", int'(match_end), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_underflow", int'(underflow), 0);

    $display("[TB] nested open/close");
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 2, 0, 0);
    applyStimulus(1, 0, 3, 0);
    applyStimulus(1, 0, 5, 0);
    finishMatch();

    $display("[TB] rollback skips abandoned entry");
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 2, 0, 0);
    applyStimulus(2, 0, 0, 0);
    checkOutput("cur_after_rollback", int'(cur_idx), 0);
    applyStimulus(0, 3, 1, 0);
    applyStimulus(1, 0, 4, 0);
    applyStimulus(1, 0, 6, 0);
    finishMatch();

    $display("[TB] nothing closed");
    applyStimulus(0, 1, 0, 0);
    finishMatch();

    $display("[TB] overflow and underflow");
    for (int i = 0; i <= DEPTH; i++) applyStimulus(0, i, i, 0);
    checkOutput("overflow_set", int'(overflow), 1);
    finishMatch();
    doReset();
    applyStimulus(1, 0, 7, 0);
    checkOutput("underflow_set", int'(underflow), 1);
    doReset();

    $display("[TB] output back-pressure");
    ready_hold = 1'b0;
    applyStimulus(0, 4, 2, 0);
    applyStimulus(0, 5, 3, 0);
    applyStimulus(1, 0, 6, 0);
    applyStimulus(1, 0, 9, 0);
    hs0 = hs_cnt;
    d0 = done_cnt;
    applyStimulus(3, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ready_hold = 1'b1;
    waitIdle(d0);
    checkOutput("handshakes", hs_cnt - hs0, 2);

    $display("[TB] reset during emission");
    ready_hold = 1'b0;
    applyStimulus(0, 8, 1, 0);
    applyStimulus(0, 9, 2, 0);
    applyStimulus(1, 0, 3, 0);
    applyStimulus(1, 0, 4, 0);
    applyStimulus(3, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    modelClear();
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_cmd_ready", int'(cmd_ready), 1);
    checkOutput("abort_cur_idx", int'(cur_idx), 0);
    rst = 1'b0;
    ready_hold = 1'b1;
    applyStimulus(0, 7, 10, 0);
    applyStimulus(1, 0, 12, 0);
    finishMatch();

    $display("[TB] randomized matches");
    ready_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(3, 25);
      for (int k = 0; k < n; k++) begin
        int p, op;
        p = $urandom_range(0, 99);
        op = (p < 40) ? 0 : (p < 75) ? 1 : 2;
        lim = (m_count + 2 > 63) ? 63 : m_count + 2;
        applyStimulus(op, $urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, lim));
      end
      finishMatch();
    end
    ready_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
